// File: rtl/prbs_bert_ctrl.sv
// prbs_bert_ctrl: sequences a PRBS loopback bit-error-rate test.
//   Resets the PRBS generator/checker, discards warm-up words, waits for the
//   checker to lock, measures bits/errors over a programmed window, and
//   reports the result.
// Ports:
//   clk, rst (async, active-low)  - clock and reset
//   start / abort                 - one-cycle control pulses
//   test_len [31:0]               - measurement length in words, 0 = until abort
//   chk_valid, chk_err [NBITS-1:0] - checker word strobe and error vector
//   prbs_rst, gen_en              - PRBS generator/checker control
//   busy, locked, done            - state indications
//   pass, sync_fail, aborted      - result flags
//   total_bits, error_bits [63:0] - saturating measurement sums
//   lock_loss [7:0]               - saturating lock-loss count
module prbs_bert_ctrl #(
    parameter int unsigned NBITS        = 8,
    parameter int unsigned RST_CYCLES   = 8,
    parameter int unsigned WARMUP_WORDS = 64,
    parameter int unsigned LOCK_WORDS   = 32,
    parameter int unsigned UNLOCK_WORDS = 4,
    parameter int unsigned SYNC_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       test_len,
    input  logic              chk_valid,
    input  logic [NBITS-1:0]  chk_err,
    output logic              prbs_rst,
    output logic              gen_en,
    output logic              busy,
    output logic              locked,
    output logic              done,
    output logic              pass,
    output logic              sync_fail,
    output logic              aborted,
    output logic [63:0]       total_bits,
    output logic [63:0]       error_bits,
    output logic [7:0]        lock_loss
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_WARMUP,
        ST_SYNC,
        ST_MEASURE,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic        r_por;        // holds prbs_rst high until the first clock after reset
    logic [31:0] r_len;
    logic [31:0] r_phase;      // RST cycle count, then WARMUP beat count
    logic [31:0] r_run;        // consecutive clean beats in SYNC
    logic [31:0] r_sync_cyc;   // cycles spent in the current SYNC visit
    logic [31:0] r_err_run;    // consecutive errored beats in MEASURE
    logic [31:0] r_word_cnt;
    logic [63:0] r_total;
    logic [63:0] r_errors;
    logic [7:0]  r_lock_loss;
    logic        r_pass;
    logic        r_sync_fail;
    logic        r_aborted;

    logic        w_busy;
    logic        w_err;
    logic [63:0] w_pop;
    logic [64:0] w_tot_sum;
    logic [64:0] w_err_sum;
    logic [63:0] w_tot_nxt;
    logic [63:0] w_err_nxt;
    logic [31:0] w_word_nxt;
    logic        w_len_hit;
    logic        w_unlock;
    logic        w_lock;
    logic        w_timeout;

    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < NBITS; i++) begin
            w_pop = w_pop + 64'(chk_err[i]);
        end
    end

    assign w_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_err      = |chk_err;
    assign w_tot_sum  = {1'b0, r_total} + 65'(NBITS);
    assign w_err_sum  = {1'b0, r_errors} + {1'b0, w_pop};
    assign w_tot_nxt  = w_tot_sum[64] ? '1 : w_tot_sum[63:0];
    assign w_err_nxt  = w_err_sum[64] ? '1 : w_err_sum[63:0];
    assign w_word_nxt = r_word_cnt + 32'd1;
    assign w_len_hit  = (r_len != '0) && (w_word_nxt == r_len);
    assign w_unlock   = w_err && ((r_err_run + 32'd1) == UNLOCK_WORDS);
    assign w_lock     = chk_valid && !w_err && ((r_run + 32'd1) == LOCK_WORDS);
    assign w_timeout  = (r_sync_cyc == SYNC_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_por       <= 1'b1;
            r_len       <= '0;
            r_phase     <= '0;
            r_run       <= '0;
            r_sync_cyc  <= '0;
            r_err_run   <= '0;
            r_word_cnt  <= '0;
            r_total     <= '0;
            r_errors    <= '0;
            r_lock_loss <= '0;
            r_pass      <= 1'b0;
            r_sync_fail <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_por <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_total     <= '0;
                        r_errors    <= '0;
                        r_lock_loss <= '0;
                        r_pass      <= 1'b0;
                        r_sync_fail <= 1'b0;
                        r_aborted   <= 1'b0;
                        r_word_cnt  <= '0;
                        r_len       <= test_len;
                        r_phase     <= '0;
                        r_state     <= ST_RST;
                    end
                end
                ST_RST: begin
                    if (r_phase == RST_CYCLES - 1) begin
                        r_phase <= '0;
                        r_state <= ST_WARMUP;
                    end else begin
                        r_phase <= r_phase + 32'd1;
                    end
                end
                ST_WARMUP: begin
                    if (chk_valid) begin
                        if (r_phase == WARMUP_WORDS - 1) begin
                            r_run      <= '0;
                            r_sync_cyc <= '0;
                            r_state    <= ST_SYNC;
                        end else begin
                            r_phase <= r_phase + 32'd1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (w_lock) begin
                        r_err_run <= '0;
                        r_state   <= ST_MEASURE;
                    end else if (w_timeout) begin
                        if (!abort) begin
                            r_sync_fail <= 1'b1;
                            r_pass      <= 1'b0;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_sync_cyc <= r_sync_cyc + 32'd1;
                        if (chk_valid) begin
                            r_run <= w_err ? '0 : r_run + 32'd1;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (chk_valid) begin
                        r_total    <= w_tot_nxt;
                        r_errors   <= w_err_nxt;
                        r_word_cnt <= w_word_nxt;
                        r_err_run  <= w_err ? r_err_run + 32'd1 : '0;
                        if (w_len_hit) begin
                            r_pass  <= (w_err_nxt == '0) && (w_tot_nxt != '0);
                            r_state <= ST_DONE;
                        end else if (w_unlock && !abort) begin
                            if (r_lock_loss != 8'hFF) begin
                                r_lock_loss <= r_lock_loss + 8'd1;
                            end
                            r_run      <= '0;
                            r_sync_cyc <= '0;
                            r_state    <= ST_SYNC;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Abort overrides whatever transition the case chose, but any
            // MEASURE beat accumulated above in this cycle is kept.
            if (abort && w_busy) begin
                r_aborted <= 1'b1;
                r_pass    <= 1'b0;
                r_state   <= ST_DONE;
            end
        end
    end

    assign prbs_rst   = r_por || (r_state == ST_RST);
    assign gen_en     = (r_state == ST_WARMUP) || (r_state == ST_SYNC) || (r_state == ST_MEASURE);
    assign busy       = w_busy;
    assign locked     = (r_state == ST_MEASURE);
    assign done       = (r_state == ST_DONE);
    assign pass       = r_pass;
    assign sync_fail  = r_sync_fail;
    assign aborted    = r_aborted;
    assign total_bits = r_total;
    assign error_bits = r_errors;
    assign lock_loss  = r_lock_loss;

endmodule

// File: tb/tb_prbs_bert_ctrl.sv
// Directed bench for prbs_bert_ctrl: instance a uses defaults, instance b
// uses SYNC_TIMEOUT = 100 for the timeout scenario.
module tb_prbs_bert_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] test_len = '0;
    logic        chk_valid = 1'b0;
    logic [7:0]  chk_err = '0;

    logic        prbs_rst, gen_en, busy, locked, done, pass, sync_fail, aborted;
    logic [63:0] total_bits, error_bits;
    logic [7:0]  lock_loss;

    logic        prbs_rst_b, gen_en_b, busy_b, locked_b, done_b, pass_b, sync_fail_b, aborted_b;
    logic [63:0] total_bits_b, error_bits_b;
    logic [7:0]  lock_loss_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prbs_bert_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .test_len(test_len),
        .chk_valid(chk_valid), .chk_err(chk_err),
        .prbs_rst(prbs_rst), .gen_en(gen_en), .busy(busy), .locked(locked), .done(done),
        .pass(pass), .sync_fail(sync_fail), .aborted(aborted),
        .total_bits(total_bits), .error_bits(error_bits), .lock_loss(lock_loss)
    );

    prbs_bert_ctrl #(.SYNC_TIMEOUT(100)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .test_len(test_len),
        .chk_valid(chk_valid), .chk_err(chk_err),
        .prbs_rst(prbs_rst_b), .gen_en(gen_en_b), .busy(busy_b), .locked(locked_b), .done(done_b),
        .pass(pass_b), .sync_fail(sync_fail_b), .aborted(aborted_b),
        .total_bits(total_bits_b), .error_bits(error_bits_b), .lock_loss(lock_loss_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic flag(input int which);
        case (which)
            0:       return done;
            1:       return locked;
            default: return done_b;
        endcase
    endfunction

    // Ticks until the selected flag is high; n == limit means it never rose.
    task automatic wait_for(input int which, input int limit, output int n);
        n = 0;
        while (n < limit && !flag(which)) begin
            tick();
            n++;
        end
    endtask

    task automatic count_rst(output int n);
        n = 0;
        while (prbs_rst && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_prbs_rst", 64'(prbs_rst), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gen_en", 64'(gen_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_total", total_bits, 64'd0);
        #9 rst = 1'b1;
        tick();
        tick();
        chk("idle_prbs_rst", 64'(prbs_rst), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Clean run: 8 RST + 64 WARMUP + 32 SYNC + 1000 MEASURE cycles
        chk_valid = 1'b1;
        chk_err   = 8'h00;
        test_len  = 32'd1000;
        pulse_start();
        chk("clean_busy", 64'(busy), 64'd1);
        chk("clean_prbs_rst", 64'(prbs_rst), 64'd1);
        wait_for(0, 3000, n);
        chk("clean_cycles", 64'(n), 64'd1104);
        chk("clean_total", total_bits, 64'd8000);
        chk("clean_errors", error_bits, 64'd0);
        chk("clean_pass", 64'(pass), 64'd1);
        chk("clean_lock_loss", 64'(lock_loss), 64'd0);
        chk("clean_gen_en", 64'(gen_en), 64'd0);
        chk("clean_busy_end", 64'(busy), 64'd0);
        tick();
        tick();
        chk("clean_hold_total", total_bits, 64'd8000);

        // Error injection: 3 single-bit errors and one 8'hFF beat
        pulse_start();
        chk("inj_cleared_total", total_bits, 64'd0);
        chk("inj_cleared_pass", 64'(pass), 64'd0);
        wait_for(1, 3000, n);
        chk("inj_lock_cycles", 64'(n), 64'd104);
        for (int i = 0; i < 41; i++) begin
            chk_err = (i == 10) ? 8'h04 : (i == 20) ? 8'h10 : (i == 30) ? 8'h80 :
                      (i == 40) ? 8'hFF : 8'h00;
            tick();
        end
        chk_err = 8'h00;
        chk("inj_mid_total", total_bits, 64'd328);
        chk("inj_mid_errors", error_bits, 64'd11);
        for (int i = 0; i < 959; i++) tick();
        chk("inj_done", 64'(done), 64'd1);
        chk("inj_total", total_bits, 64'd8000);
        chk("inj_errors", error_bits, 64'd11);
        chk("inj_pass", 64'(pass), 64'd0);
        chk("inj_lock_loss", 64'(lock_loss), 64'd0);

        // Lock loss: 10 clean + 4 errored beats, relock, finish at 100 words
        test_len = 32'd100;
        pulse_start();
        wait_for(1, 3000, n);
        chk("ll_lock_cycles", 64'(n), 64'd104);
        for (int i = 0; i < 10; i++) tick();
        chk_err = 8'h01;
        for (int i = 0; i < 3; i++) tick();
        chk("ll_still_locked", 64'(locked), 64'd1);
        tick();
        chk_err = 8'h00;
        chk("ll_unlocked", 64'(locked), 64'd0);
        chk("ll_busy", 64'(busy), 64'd1);
        chk("ll_lock_loss", 64'(lock_loss), 64'd1);
        chk("ll_total_held", total_bits, 64'd112);
        chk("ll_errors", error_bits, 64'd4);
        wait_for(1, 200, n);
        chk("ll_relock_beats", 64'(n), 64'd32);
        chk("ll_total_after_relock", total_bits, 64'd112);
        wait_for(0, 200, n);
        chk("ll_rest_beats", 64'(n), 64'd86);
        chk("ll_final_total", total_bits, 64'd800);
        chk("ll_final_errors", error_bits, 64'd4);
        chk("ll_final_pass", 64'(pass), 64'd0);

        // Sync timeout on instance b: 8 RST + 64 WARMUP + 100 SYNC cycles
        chk_err = 8'h01;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_for(2, 1000, n);
        chk("to_cycles", 64'(n), 64'd172);
        chk("to_sync_fail", 64'(sync_fail_b), 64'd1);
        chk("to_pass", 64'(pass_b), 64'd0);
        chk("to_total", total_bits_b, 64'd0);
        chk("to_lock_loss", 64'(lock_loss_b), 64'd0);
        chk("to_a_held", total_bits, 64'd800);
        chk_err = 8'h00;

        // Abort and start collision in an unbounded run
        test_len = 32'd0;
        pulse_start();
        wait_for(1, 3000, n);
        chk("ab_lock_cycles", 64'(n), 64'd104);
        for (int i = 0; i < 20; i++) tick();
        chk("ab_still_locked", 64'(locked), 64'd1);
        chk("ab_running_total", total_bits, 64'd160);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("ab_done", 64'(done), 64'd1);
        chk("ab_aborted", 64'(aborted), 64'd1);
        chk("ab_total", total_bits, 64'd168);
        chk("ab_pass", 64'(pass), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("ab_hold_total", total_bits, 64'd168);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_done_abort_ignored", 64'(done), 64'd1);
        pulse_start();
        chk("ab_restart_total", total_bits, 64'd0);
        chk("ab_restart_aborted", 64'(aborted), 64'd0);
        count_rst(n);
        chk("ab_rst_pulse_len", 64'(n), 64'd8);
        chk("ab_gen_en_after_rst", 64'(gen_en), 64'd1);

        // Mid-test reset in WARMUP, between clock edges
        for (int i = 0; i < 5; i++) tick();
        chk("mr_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("mr_prbs_rst", 64'(prbs_rst), 64'd1);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_gen_en", 64'(gen_en), 64'd0);
        chk("mr_total", total_bits, 64'd0);
        chk("mr_b_sync_fail", 64'(sync_fail_b), 64'd0);
        chk("mr_b_done", 64'(done_b), 64'd0);
        #2 rst = 1'b1;
        tick();
        tick();
        chk("mr_idle_prbs_rst", 64'(prbs_rst), 64'd0);
        chk("mr_idle_busy", 64'(busy), 64'd0);

        // Abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("idle_abort_aborted", 64'(aborted), 64'd0);
        chk("idle_abort_done", 64'(done), 64'd0);
        chk("idle_abort_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
